// File: rtl/input_conditioner.sv
// Debounces six asynchronous user inputs and latches a one-hot row/column selection from the switches.
// Optional macro FIRE_AUTOREPEAT_EN adds a periodic fire_pulse while fire stays held.

module ic_debounce #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);
  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d   = {sync_q[0], raw};
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) stable_d = sync_q[1];
      else                                cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign db = stable_q;
endmodule

module input_conditioner #(
  parameter int DB_CYCLES     = 1000000,
  parameter int CNT_W         = 20,
  parameter int REPEAT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire_btn_raw,
  input  logic [3:0] sw_raw,
  input  logic       nrow_raw,
  output logic       fire_pulse,
  output logic [3:0] sw_db,
  output logic       nrow_db,
  output logic [3:0] row_sel,
  output logic [3:0] col_sel,
  output logic       sel_error
);
  localparam int NUM_CH = 6;

  if (DB_CYCLES < 1 || REPEAT_CYCLES < 1 || (DB_CYCLES - 1) >= (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("input_conditioner: invalid DB_CYCLES/CNT_W/REPEAT_CYCLES");
  end

  // channel order: {fire, nrow, sw[3:0]}
  logic [NUM_CH-1:0] raw_vec, db_vec;
  assign raw_vec = {fire_btn_raw, nrow_raw, sw_raw};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ic_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_vec[i]),
      .db    (db_vec[i])
    );
  end

  logic       fire_db, one_hot;
  logic       fire_prev_q, fire_prev_d;
  logic       fire_pulse_q, fire_pulse_d;
  logic       sel_error_q, sel_error_d;
  logic [3:0] row_sel_q, row_sel_d, col_sel_q, col_sel_d;

  assign sw_db   = db_vec[3:0];
  assign nrow_db = db_vec[4];
  assign fire_db = db_vec[5];
  assign one_hot = (sw_db != 4'b0) && ((sw_db & (sw_db - 4'd1)) == 4'b0);

`ifdef FIRE_AUTOREPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_hit;

  assign rpt_hit = (rpt_cnt_q == RPT_W'(REPEAT_CYCLES - 1));

  // Count restarts at the initial pulse so repeats land every REPEAT_CYCLES after it.
  always_comb begin
    rpt_cnt_d = '0;
    if (fire_db && fire_prev_q && !rpt_hit) rpt_cnt_d = rpt_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) rpt_cnt_q <= '0;
    else       rpt_cnt_q <= rpt_cnt_d;
  end
`endif

  always_comb begin
    fire_prev_d  = fire_db;
`ifdef FIRE_AUTOREPEAT_EN
    fire_pulse_d = fire_db && (!fire_prev_q || rpt_hit);
`else
    fire_pulse_d = fire_db && !fire_prev_q;
`endif
    sel_error_d  = !one_hot;
    row_sel_d    = row_sel_q;
    col_sel_d    = col_sel_q;
    if (one_hot) begin
      if (nrow_db) col_sel_d = sw_db;
      else         row_sel_d = sw_db;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_prev_q  <= 1'b0;
      fire_pulse_q <= 1'b0;
      sel_error_q  <= 1'b1;
      row_sel_q    <= '0;
      col_sel_q    <= '0;
    end else begin
      fire_prev_q  <= fire_prev_d;
      fire_pulse_q <= fire_pulse_d;
      sel_error_q  <= sel_error_d;
      row_sel_q    <= row_sel_d;
      col_sel_q    <= col_sel_d;
    end
  end

  assign fire_pulse = fire_pulse_q;
  assign sel_error  = sel_error_q;
  assign row_sel    = row_sel_q;
  assign col_sel    = col_sel_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner (DB_CYCLES=4, REPEAT_CYCLES=8): directed table, fire sequences, random vs model.

module tb_input_conditioner;
  localparam int DB  = 4;
  localparam int RPT = 8;

  logic       clk = 1'b0;
  logic       reset, fire_btn_raw, nrow_raw;
  logic [3:0] sw_raw;
  logic       fire_pulse, nrow_db, sel_error;
  logic [3:0] sw_db, row_sel, col_sel;

  input_conditioner #(.DB_CYCLES(DB), .CNT_W(3), .REPEAT_CYCLES(RPT)) dut (
    .clk(clk), .reset(reset), .fire_btn_raw(fire_btn_raw), .sw_raw(sw_raw),
    .nrow_raw(nrow_raw), .fire_pulse(fire_pulse), .sw_db(sw_db), .nrow_db(nrow_db),
    .row_sel(row_sel), .col_sel(col_sel), .sel_error(sel_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a level reaches the debounced output once the raw input, seen two
  // edges late through the synchronizer, has disagreed with it for DB consecutive edges.
  logic [5:0] rawq[$];
  logic [5:0] m_stab;
  logic [3:0] m_row, m_col;
  logic       m_err, m_pulse;
  int         m_hold;
  int         edge_no;

  task automatic model_edge(input logic rst, input logic [5:0] raw);
    logic [5:0] old;
    bit         flip;
    int         n;
    if (rst) begin
      rawq.delete();
      repeat (DB + 2) rawq.push_back(6'b0);
      m_stab = '0; m_row = '0; m_col = '0; m_err = 1'b1; m_pulse = 1'b0; m_hold = 0;
      return;
    end
    old = m_stab;
    m_err = ($countones(old[3:0]) != 1);
    if (!m_err) begin
      if (old[4]) m_col = old[3:0];
      else        m_row = old[3:0];
    end
    m_hold = old[5] ? m_hold + 1 : 0;
`ifdef FIRE_AUTOREPEAT_EN
    m_pulse = (m_hold > 0) && (((m_hold - 1) % RPT) == 0);
`else
    m_pulse = (m_hold == 1);
`endif
    n = rawq.size();
    for (int b = 0; b < 6; b++) begin
      flip = 1'b1;
      for (int j = 2; j <= DB + 1; j++)
        if (rawq[n-j][b] == m_stab[b]) flip = 1'b0;
      if (flip) m_stab[b] = ~m_stab[b];
    end
    rawq.push_back(raw);
    void'(rawq.pop_front());
  endtask

  task automatic step(input logic rst, input logic fire, input logic [3:0] sw, input logic nrow);
    reset = rst; fire_btn_raw = fire; sw_raw = sw; nrow_raw = nrow;
    @(posedge clk);
    edge_no = rst ? 0 : edge_no + 1;
    model_edge(rst, {fire, nrow, sw});
    #1;
    check("model", {27'b0, fire_pulse, sw_db, nrow_db, row_sel, col_sel, sel_error},
          {27'b0, m_pulse, m_stab[3:0], m_stab[4], m_row, m_col, m_err});
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] sw;
    logic       nrow;
    int         cycles;
    logic [3:0] e_sw;
    logic       e_nrow;
    logic [3:0] e_row;
    logic [3:0] e_col;
    logic       e_err;
  } vec_t;

  vec_t vt[12];
  int   pulses;
  int   pedges[$];

  initial begin
    reset = 1'b1; fire_btn_raw = 1'b0; sw_raw = '0; nrow_raw = 1'b0; edge_no = 0;

    vt[0]  = '{1'b1, 4'b0000, 1'b0, 2, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vt[1]  = '{1'b0, 4'b0100, 1'b0, 5, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vt[2]  = '{1'b0, 4'b0100, 1'b0, 1, 4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vt[3]  = '{1'b0, 4'b0100, 1'b0, 1, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0};
    vt[4]  = '{1'b0, 4'b0011, 1'b1, 6, 4'b0011, 1'b1, 4'b0100, 4'b0000, 1'b0};
    vt[5]  = '{1'b0, 4'b0011, 1'b1, 1, 4'b0011, 1'b1, 4'b0100, 4'b0000, 1'b1};
    vt[6]  = '{1'b0, 4'b0010, 1'b1, 7, 4'b0010, 1'b1, 4'b0100, 4'b0010, 1'b0};
    vt[7]  = '{1'b0, 4'b1000, 1'b1, 3, 4'b0010, 1'b1, 4'b0100, 4'b0010, 1'b0};
    vt[8]  = '{1'b0, 4'b0010, 1'b1, 6, 4'b0010, 1'b1, 4'b0100, 4'b0010, 1'b0};
    vt[9]  = '{1'b0, 4'b0001, 1'b0, 4, 4'b0010, 1'b1, 4'b0100, 4'b0010, 1'b0};
    vt[10] = '{1'b1, 4'b0001, 1'b0, 1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vt[11] = '{1'b0, 4'b0001, 1'b0, 5, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};

    foreach (vt[i]) begin
      repeat (vt[i].cycles) step(vt[i].rst, 1'b0, vt[i].sw, vt[i].nrow);
      check($sformatf("vec%0d", i), {15'b0, sw_db, nrow_db, row_sel, col_sel, sel_error},
            {15'b0, vt[i].e_sw, vt[i].e_nrow, vt[i].e_row, vt[i].e_col, vt[i].e_err});
    end
    // sw_db appears exactly one edge later, at edge 6 after release
    step(1'b0, 1'b0, 4'b0001, 1'b0);
    check("rst_release_edge6", {28'b0, sw_db}, 32'h1);
    check("rst_release_edge_no", edge_no, 6);

    // Held fire press: pulse edges relative to the change
    step(1'b1, 1'b0, 4'b0000, 1'b0);
    pedges.delete();
    repeat (30) begin
      step(1'b0, 1'b1, 4'b0000, 1'b0);
      if (fire_pulse) pedges.push_back(edge_no);
    end
`ifdef FIRE_AUTOREPEAT_EN
    check("rpt_count", pedges.size(), 3);
    if (pedges.size() == 3) begin
      check("rpt_e0", pedges[0], 7);
      check("rpt_e1", pedges[1], 15);
      check("rpt_e2", pedges[2], 23);
    end
`else
    check("press_count", pedges.size(), 1);
    if (pedges.size() == 1) check("press_edge", pedges[0], 7);
`endif
    pulses = 0;
    repeat (12) begin
      step(1'b0, 1'b0, 4'b0000, 1'b0);
      pulses += fire_pulse;
    end
    check("release_pulses", pulses, 0);

    // 3-cycle glitch must be swallowed
    pulses = 0;
    repeat (3) begin step(1'b0, 1'b1, 4'b0000, 1'b0); pulses += fire_pulse; end
    repeat (12) begin step(1'b0, 1'b0, 4'b0000, 1'b0); pulses += fire_pulse; end
    check("glitch_pulses", pulses, 0);

    // Random holds of varying length, occasional reset
    for (int r = 0; r < 400; r++) begin
      logic       rf, rn, rr;
      logic [3:0] rs;
      int         len;
      rf  = 1'($urandom);
      rn  = 1'($urandom);
      rs  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      rr  = ($urandom_range(0, 40) == 0);
      len = rr ? 1 : $urandom_range(1, 9);
      repeat (len) step(rr, rf, rs, rn);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
